// File: rtl/fp_mult_pkg.sv
// Shared types for the fp_mult result path: rounding-mode tags, status bit
// positions and the packed result record carried through the collector FIFO.
package fp_mult_pkg;

    typedef enum logic [2:0] {
        IEEE_near = 3'b000,
        IEEE_zero = 3'b001,
        IEEE_pinf = 3'b010,
        IEEE_ninf = 3'b011,
        near_up   = 3'b100,
        away_zero = 3'b101
    } rnd_t;

    // status bit positions; bits 7:6 are reserved
    localparam int ZERO    = 0;
    localparam int INF     = 1;
    localparam int NAN     = 2;
    localparam int TINY    = 3;
    localparam int HUGE    = 4;
    localparam int INEXACT = 5;

    typedef struct packed {
        logic [31:0] z;
        logic [7:0]  status;
        rnd_t        rnd;
    } result_t;

endpackage

// File: rtl/fp_result_fifo.sv
// Show-ahead circular FIFO of multiplier results. Pointers carry one extra
// bit so full and empty are told apart without a separate flag. A push into
// a full FIFO is accepted when a pop happens in the same cycle.
module fp_result_fifo
    import fp_mult_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  result_t                    push_data,
    output logic                       push_ok,
    input  logic                       pop,
    output result_t                    head,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    result_t     mem [DEPTH];
    logic        full;
    logic        do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign push_ok = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // pointer update; reset empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // storage write; contents need no reset since head is masked when empty
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fp_mult_collect.sv
// Collector behind fp_mult_top. A valid/tag delay line follows each issued
// operation through the multiplier's fixed latency; when it reaches the last
// stage the multiplier output is captured into the result FIFO. Credits count
// both queued and in-flight results, so a compliant upstream never overflows.
module fp_mult_collect
    import fp_mult_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [2:0]  issue_rnd,
    output logic        issue_ready,
    input  logic [31:0] mult_z,
    input  logic [7:0]  mult_status,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_z,
    output logic [7:0]  out_status,
    output logic [2:0]  out_rnd,
    output logic [7:0]  sticky_status,
    input  logic        sticky_clr,
    output logic [7:0]  drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = 6;   // holds DEPTH + LATENCY for the largest legal sizes

    logic [LATENCY-1:0] stg_vld;
    rnd_t               stg_rnd [LATENCY];
    logic               credit_ok;
    logic               launch;
    logic               capture;
    logic [3:0]         inflight;
    result_t            cap_data;
    result_t            head;
    logic               empty;
    logic               push_ok;
    logic [AW:0]        count;

    assign launch      = issue_valid & credit_ok;
    assign issue_ready = credit_ok;
    assign capture     = stg_vld[LATENCY-1];

    always_comb begin
        cap_data        = '0;
        cap_data.z      = mult_z;
        cap_data.status = mult_status;
        cap_data.rnd    = stg_rnd[LATENCY-1];
    end

    // valid half of the delay line; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_vld <= '0;
        end else begin
            stg_vld[0] <= launch;
            for (int i = 1; i < LATENCY; i++) stg_vld[i] <= stg_vld[i-1];
        end
    end

    // tag half of the delay line; only meaningful alongside a valid stage
    always_ff @(posedge clk) begin
        stg_rnd[0] <= rnd_t'(issue_rnd);
        for (int i = 1; i < LATENCY; i++) stg_rnd[i] <= stg_rnd[i-1];
    end

    // results still inside the multiplier hold a credit until captured
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) inflight = inflight + 4'(stg_vld[i]);
    end

    // credit check: queued plus in-flight must leave room for one more
    always_comb begin
        credit_ok = ((SW'(count) + SW'(inflight)) < SW'(DEPTH));
    end

    fp_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (cap_data),
        .push_ok   (push_ok),
        .pop       (out_ready),
        .head      (head),
        .empty     (empty),
        .count     (count)
    );

    assign out_valid  = ~empty;
    assign out_z      = head.z;
    assign out_status = head.status;
    assign out_rnd    = head.rnd;

    // sticky flags: a capture in the same cycle as a clear is kept
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_status <= '0;
        end else begin
            sticky_status <= (sticky_clr ? 8'h00 : sticky_status)
                           | (capture ? mult_status : 8'h00);
        end
    end

    // saturating count of captures refused by a full FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (capture && !push_ok && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_fp_mult_collect.sv
// Bench for fp_mult_collect: a behavioural upstream pipeline supplies
// mult_z/mult_status LATENCY cycles after issue, a scoreboard queue holds the
// expected results, and a monitor pops and compares on every handshake.
module tb_fp_mult_collect;
    import fp_mult_pkg::*;

    localparam int L = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [2:0]  issue_rnd;
    logic        issue_ready;
    logic [31:0] mult_z;
    logic [7:0]  mult_status;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic [7:0]  out_status;
    logic [2:0]  out_rnd;
    logic [7:0]  sticky_status;
    logic        sticky_clr;
    logic [7:0]  drop_cnt;

    logic [31:0] iss_z;
    logic [7:0]  iss_st;
    logic [39:0] up_pipe [L];

    result_t exp_q[$];
    int      pop_cyc[$];
    int      n_chk = 0;
    int      n_fail = 0;
    int      cyc = 0;
    int      launches = 0;
    int      pops = 0;
    int      flushed = 0;
    int      outs_snap = 0;
    logic [7:0] sticky_exp = 8'h00;

    fp_mult_collect #(
        .LATENCY (L),
        .DEPTH   (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rnd     (issue_rnd),
        .issue_ready   (issue_ready),
        .mult_z        (mult_z),
        .mult_status   (mult_status),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_z         (out_z),
        .out_status    (out_status),
        .out_rnd       (out_rnd),
        .sticky_status (sticky_status),
        .sticky_clr    (sticky_clr),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    // stand-in for fp_mult_top: operands appear at the output L cycles later
    always @(posedge clk) begin
        up_pipe[0] <= {iss_z, iss_st};
        for (int i = 1; i < L; i++) up_pipe[i] <= up_pipe[i-1];
    end
    assign mult_z      = up_pipe[L-1][39:8];
    assign mult_status = up_pipe[L-1][7:0];

    // cycle count and credit occupancy as seen at the start of each cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        outs_snap <= rst ? 0 : (launches - pops - flushed);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                chk("out_z", 64'(out_z), 64'(e.z));
                chk("out_status", 64'(out_status), 64'(e.status));
                chk("out_rnd", 64'(out_rnd), 64'(e.rnd));
            end
            pops++;
            pop_cyc.push_back(cyc);
        end
    end

    // entered #1 after a rising edge; returns #1 after the next one
    task automatic issue(input logic [31:0] z, input logic [7:0] st, input logic [2:0] r);
        bit exp_rdy;
        result_t e;
        issue_valid = 1'b1;
        iss_z       = z;
        iss_st      = st;
        issue_rnd   = r;
        @(negedge clk);
        if (!rst) begin
            exp_rdy = (outs_snap < D);
            chk("issue_ready", 64'(issue_ready), 64'(exp_rdy));
            if (exp_rdy) begin
                e.z      = z;
                e.status = st;
                e.rnd    = rnd_t'(r);
                exp_q.push_back(e);
                launches++;
                sticky_exp = sticky_exp | st;
            end
        end
        @(posedge clk); #1;
        issue_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic clear_sticky();
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        sticky_exp = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int l0;
        rst         = 1'b1;
        issue_valid = 1'b0;
        issue_rnd   = 3'b000;
        iss_z       = 32'h0;
        iss_st      = 8'h0;
        out_ready   = 1'b1;
        sticky_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_z", 64'(out_z), 64'd0);
        chk("rst_out_status", 64'(out_status), 64'd0);
        chk("rst_out_rnd", 64'(out_rnd), 64'd0);
        chk("rst_sticky", 64'(sticky_status), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        @(posedge clk); #1;

        // reset arriving while operations are in flight
        issue(32'h3F800000, 8'h01, 3'b000);
        rst = 1'b1;
        issue(32'h40000000, 8'h02, 3'b001);
        issue(32'h40400000, 8'h04, 3'b010);
        rst = 1'b0;
        exp_q.delete();
        flushed    = launches - pops;
        sticky_exp = 8'h00;
        @(negedge clk);
        chk("midrst_issue_ready", 64'(issue_ready), 64'd1);
        for (int i = 0; i < L + 4; i++) begin
            chk("midrst_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        chk("midrst_sticky", 64'(sticky_status), 64'd0);
        chk("midrst_drop", 64'(drop_cnt), 64'd0);
        @(posedge clk); #1;

        // single op: latency and tag
        t0 = cyc;
        issue(32'h3F800000, 8'h20, 3'b101);
        @(negedge clk);
        while (!out_valid && (cyc - t0) < 20) @(negedge clk);
        chk("lat_cycles", 64'(cyc - t0), 64'(L + 1));
        chk("lat_out_z", 64'(out_z), 64'h3F800000);
        chk("lat_out_status", 64'(out_status), 64'h20);
        chk("lat_out_rnd", 64'(out_rnd), 64'h5);
        @(posedge clk); #1;
        wait_drain();

        // back-to-back, one op per rounding mode
        pop_cyc.delete();
        for (int i = 0; i < 6; i++)
            issue(32'h40000000 + 32'(i), 8'(1 << i), 3'(i));
        wait_drain();
        chk("b2b_count", 64'(pop_cyc.size()), 64'd6);
        if (pop_cyc.size() == 6)
            chk("b2b_span", 64'(pop_cyc[5] - pop_cyc[0]), 64'd5);
        chk("b2b_drop", 64'(drop_cnt), 64'd0);

        // backpressure: only DEPTH launches fit
        out_ready = 1'b0;
        l0 = launches;
        for (int i = 0; i < 6; i++)
            issue(32'h41000000 + 32'(i), 8'h01, 3'(i));
        chk("bp_launched", 64'(launches - l0), 64'd4);
        repeat (L + 2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        chk("bp_issue_ready", 64'(issue_ready), 64'd0);
        chk("bp_drop", 64'(drop_cnt), 64'd0);
        @(posedge clk); #1;

        // forced capture into the full FIFO
        clear_sticky();
        force dut.credit_ok = 1'b1;
        issue_valid = 1'b1;
        iss_z       = 32'hDEADBEEF;
        iss_st      = 8'h10;
        issue_rnd   = 3'b011;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        release dut.credit_ok;
        sticky_exp = sticky_exp | 8'h10;
        repeat (L) @(posedge clk);
        #1;
        @(negedge clk);
        chk("ovf_drop", 64'(drop_cnt), 64'd1);
        chk("ovf_sticky", 64'(sticky_status), 64'(sticky_exp));
        chk("ovf_out_valid", 64'(out_valid), 64'd1);
        chk("ovf_head_z", 64'(out_z), 64'(exp_q[0].z));
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        chk("ovf_empty_after", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // sticky clear racing with a capture
        clear_sticky();
        issue(32'h3F000000, 8'h21, 3'b000);
        repeat (L + 1) @(posedge clk);
        #1;
        @(negedge clk);
        chk("sticky_pre", 64'(sticky_status), 64'h21);
        @(posedge clk); #1;
        issue(32'h3E000000, 8'h04, 3'b001);
        repeat (L - 1) @(posedge clk);
        #1;
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        @(negedge clk);
        chk("sticky_race", 64'(sticky_status), 64'h04);
        @(posedge clk); #1;
        wait_drain();
        chk("final_drop", 64'(drop_cnt), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mult_collect.md
Name: fp_mult_collect

Overview:
- Downstream stage of fp_mult_top; consumes its z/status results.
- Tracks the multiplier's fixed pipeline latency with a valid/tag delay line.
- Captures each result into a small FIFO, exposes it on a valid/ready output port, and keeps sticky exception flags.
- Gives upstream a credit-based issue_ready so no multiplier result is ever lost when the protocol is obeyed.

Parameters:
- LATENCY, 2, clock cycles from operand issue to valid z/status at the fp_mult_top outputs (1..8).
- DEPTH, 4, FIFO entries (power of two, 2..16).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- issue_valid  input  1  high in the cycle a/b/rnd are presented to fp_mult_top.
- issue_rnd  input  3  rounding mode issued with the operands; carried as tag.
- issue_ready  output  1  upstream may assert issue_valid this cycle.
- mult_z  input  32  fp_mult_top z.
- mult_status  input  8  fp_mult_top status.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_z  output  32  head result.
- out_status  output  8  head status.
- out_rnd  output  3  head rounding-mode tag.
- sticky_status  output  8  OR of all captured statuses since reset/clear.
- sticky_clr  input  1  clear sticky_status.
- drop_cnt  output  8  saturating count of results lost to a full FIFO.

Behaviour:
- Reset: clk and rst only; reset is synchronous and active-high. On rst high at an edge:
  - delay line and FIFO are emptied.
  - out_valid=0, out_z=0, out_status=0, out_rnd=0.
  - sticky_status=0, drop_cnt=0.
  - issue_ready=1 in the cycle after reset.
  - Reset mid-operation discards all in-flight and queued results.
- Delay line: LATENCY-stage shift register of {valid, rnd}.
  - Stage 0 loads {issue_valid & issue_ready, issue_rnd} at each edge.
  - The tap at stage LATENCY-1 marks a capture cycle: mult_z/mult_status are sampled at the next edge together with the tag.
- Credit rule: issue_ready = (fifo_count + inflight) < DEPTH, where inflight = number of valid delay stages.
  - issue_valid while issue_ready=0 is not launched and is not tracked.
- FIFO: standard circular buffer with pointers one bit wider than the index; wrap-around is natural.
  - A pop occurs when out_valid & out_ready.
  - Push and pop in the same cycle are allowed, including when the FIFO is full: count is unchanged and the push succeeds.
  - Show-ahead output: out_* reflect the head combinationally from storage; out_z/out_status/out_rnd are 0 when empty.
  - A pushed entry appears on out_valid in the cycle after capture (1 cycle of FIFO latency).
- Full at capture with no simultaneous pop: the result is dropped and drop_cnt increments, saturating at 255.
  - This is unreachable when upstream honours issue_ready.
- Sticky status:
  - next = (sticky_clr ? 0 : sticky_status) | (capture ? mult_status : 0).
  - A capture in the same cycle as a clear survives.
  - Dropped results still update sticky_status.
- Total latency issue→out_valid = LATENCY+1 cycles.
  - Throughput is 1 result/cycle while out_ready stays high.

Decomposition:
- Package fp_mult_pkg holds:
  - rnd_t encodings: IEEE_near=000, IEEE_zero=001, IEEE_pinf=010, IEEE_ninf=011, near_up=100, away_zero=101.
  - Status bit indices: ZERO=0, INF=1, NAN=2, TINY=3, HUGE=4, INEXACT=5; bits 7:6 reserved.
  - result_t struct {z, status, rnd}.
- One sub-module, fp_result_fifo (parameterised DEPTH, result_t payload).
- The delay line, credit logic and sticky/drop logic stay in the top.

Test Plan:
- Reset mid-stream:
  - Stimulus: issue 3 ops, assert rst on the 2nd cycle.
  - Required: out_valid stays 0, sticky_status=0, drop_cnt=0, issue_ready=1 next cycle.
- Latency/tag:
  - Stimulus: issue one op with rnd=3'b101; drive mult_z=32'h3F800000, mult_status=8'h20 at the tap cycle.
  - Required: exactly LATENCY+1 cycles after issue, out_valid=1, out_z=32'h3F800000, out_status=8'h20, out_rnd=3'b101.
- Back-to-back:
  - Stimulus: 6 ops in consecutive cycles with out_ready=1, one per rnd mode 000..101.
  - Required: 6 results appear in order on consecutive cycles; no drops.
- Backpressure/credit:
  - Stimulus: out_ready=0, try 6 ops.
  - Required: issue_ready falls after 4 launches (DEPTH=4); 4 entries held; drop_cnt=0. Then out_ready=1 drains 4 entries in order.
- Forced overflow:
  - Stimulus: FIFO full, out_ready=0, force a tap-cycle capture.
  - Required: drop_cnt=1, FIFO contents unchanged, sticky_status ORs the dropped status.
- Sticky clear race:
  - Stimulus: sticky=8'h21, assert sticky_clr in a capture cycle with status 8'h04.
  - Required: sticky_status=8'h04.
